// File: rtl/cross_arb_pkg.sv
// Shared defaults, derived widths and reset constants for the cross_arb slice.
// Build option: define CROSS_ARB_STALL_EN to enable result back-pressure.
package cross_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int W_DEF      = 11;
    localparam int ID_W_DEF   = $clog2(NREQ_DEF);
    localparam int PROD_W_DEF = 2 * W_DEF;
    localparam int RES_W_DEF  = 2 * W_DEF + 1;

    localparam logic        RST_VLD  = 1'b0;
    localparam logic        RST_POS  = 1'b0;
    localparam logic [15:0] RST_CNT  = 16'h0000;
    localparam logic [15:0] TXN_MAX  = 16'hFFFF;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int res_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/cross_arb_mul.sv
// Two-stage signed cross-product pipeline (ax*by - ay*bx) with a global enable.
// Build option: none here; the enable is driven low by cross_arb under CROSS_ARB_STALL_EN.
module cross_mul
    import cross_arb_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_vld,
    input  logic [ID_W-1:0]        in_id,
    input  logic signed [W-1:0]    ax,
    input  logic signed [W-1:0]    ay,
    input  logic signed [W-1:0]    bx,
    input  logic signed [W-1:0]    by,
    output logic                   vld_p2,
    output logic [ID_W-1:0]        id_p2,
    output logic signed [2*W:0]    val_p2,
    output logic                   pos_p2
);

    localparam int PROD_W = prod_w(W);
    localparam int RES_W  = res_w(W);

    logic signed [PROD_W-1:0] ax_e, ay_e, bx_e, by_e;
    logic signed [PROD_W-1:0] axby_p1, aybx_p1;
    logic [ID_W-1:0]          id_p1;
    logic                     vld_p1;
    logic signed [RES_W-1:0]  diff;

    assign ax_e = PROD_W'(ax);
    assign ay_e = PROD_W'(ay);
    assign bx_e = PROD_W'(bx);
    assign by_e = PROD_W'(by);

    // Stage 1: both partial products at full 2W precision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= RST_VLD;
        end else if (en) begin
            vld_p1 <= in_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (en && in_vld) begin
            axby_p1 <= ax_e * by_e;
            aybx_p1 <= ay_e * bx_e;
            id_p1   <= in_id;
        end
    end

    assign diff = RES_W'(axby_p1) - RES_W'(aybx_p1);

    // Stage 2: difference, sign flag and owner id; held between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2 <= RST_VLD;
            id_p2  <= '0;
            val_p2 <= '0;
            pos_p2 <= RST_POS;
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                id_p2  <= id_p1;
                val_p2 <= diff;
                pos_p2 <= !diff[RES_W-1] && (|diff);
            end
        end
    end

endmodule

// File: rtl/cross_arb.sv
// Round-robin arbiter feeding a shared signed cross-product pipeline.
// Build option: define CROSS_ARB_STALL_EN to let res_ready stall the pipeline and grants.
module cross_arb
    import cross_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*W-1:0]           op_ax,
    input  logic [NREQ*W-1:0]           op_ay,
    input  logic [NREQ*W-1:0]           op_bx,
    input  logic [NREQ*W-1:0]           op_by,
    output logic [NREQ-1:0]             gnt,
    output logic                        res_valid,
    output logic [$clog2(NREQ)-1:0]     res_id,
    output logic signed [2*W:0]         res_val,
    output logic                        res_pos,
    input  logic                        res_ready,
    output logic [15:0]                 txn_cnt
);

    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic                stall;
    logic                en;
    int                  idx;
    logic signed [W-1:0] ax_sel, ay_sel, bx_sel, by_sel;

`ifdef CROSS_ARB_STALL_EN
    assign stall = res_valid & ~res_ready;
`else
    logic unused_ready;
    assign unused_ready = res_ready;
    assign stall        = 1'b0;
`endif

    assign en = ~stall;

    // Search starts at rr_ptr and wraps; a stall suppresses every grant
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_any && !stall && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ax_sel = op_ax[int'(gnt_idx)*W +: W];
        ay_sel = op_ay[int'(gnt_idx)*W +: W];
        bx_sel = op_bx[int'(gnt_idx)*W +: W];
        by_sel = op_by[int'(gnt_idx)*W +: W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            txn_cnt <= RST_CNT;
        end else if (gnt_any) begin
            rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + ID_W'(1);
            if (txn_cnt != TXN_MAX) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
        end
    end

    cross_mul #(
        .W    (W),
        .ID_W (ID_W)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .in_vld (gnt_any),
        .in_id  (gnt_idx),
        .ax     (ax_sel),
        .ay     (ay_sel),
        .bx     (bx_sel),
        .by     (by_sel),
        .vld_p2 (res_valid),
        .id_p2  (res_id),
        .val_p2 (res_val),
        .pos_p2 (res_pos)
    );

endmodule

// File: tb/tb_cross_arb.sv
// Self-checking bench for cross_arb: directed vectors, grant sequences, reset and random traffic.
// Build option: the back-pressure sequence runs only when CROSS_ARB_STALL_EN is defined.
module tb_cross_arb;

    localparam int NREQ  = 4;
    localparam int W     = 11;
    localparam int ID_W  = 2;
    localparam int RES_W = 2 * W + 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*W-1:0]       op_ax = '0, op_ay = '0, op_bx = '0, op_by = '0;
    logic [NREQ-1:0]         gnt;
    logic                    res_valid;
    logic [ID_W-1:0]         res_id;
    logic signed [RES_W-1:0] res_val;
    logic                    res_pos;
    logic                    res_ready = 1'b1;
    logic [15:0]             txn_cnt;

    cross_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_ax     (op_ax),
        .op_ay     (op_ay),
        .op_bx     (op_bx),
        .op_by     (op_by),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_val   (res_val),
        .res_pos   (res_pos),
        .res_ready (res_ready),
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of results with the cycle they are due, plus held outputs
    typedef struct { int id; longint val; int due; } res_t;
    res_t            pend[$];
    int              m_ptr = 0, m_cnt = 0, cyc = 0, m_id = 0;
    bit              m_vld = 1'b0;
    longint          m_val = 0;
    bit              model_on = 1'b1;
    logic [NREQ-1:0] last_gnt;

    typedef struct { int id; int ax; int ay; int bx; int by; longint val; bit pos; } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint opnd(input logic [NREQ*W-1:0] bus, input int i);
        logic signed [W-1:0] s;
        s = bus[i*W +: W];
        return longint'(s);
    endfunction

    function automatic int exp_winner();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 11'h3FF;
            1:       return 11'h400;
            2:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_ops(input int i, input int ax, input int ay, input int bx, input int by);
        logic [31:0] t;
        t = ax; op_ax[i*W +: W] = t[W-1:0];
        t = ay; op_ay[i*W +: W] = t[W-1:0];
        t = bx; op_bx[i*W +: W] = t[W-1:0];
        t = by; op_by[i*W +: W] = t[W-1:0];
    endtask

    task automatic step();
        int   w;
        res_t r;
        @(negedge clk);
        w = exp_winner();
        last_gnt = gnt;
        if (model_on) begin
            chk("gnt", longint'(gnt), (w < 0) ? 0 : (1 << w));
            chk("res_valid", longint'(res_valid), longint'(m_vld));
            chk("res_id", longint'(res_id), m_id);
            chk("res_val", longint'(res_val), m_val);
            chk("res_pos", longint'(res_pos), (m_val > 0) ? 1 : 0);
            chk("txn_cnt", longint'(txn_cnt), m_cnt);
        end
        @(posedge clk);
        cyc++;
        if (model_on) begin
            m_vld = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                m_vld = 1'b1;
                m_id  = r.id;
                m_val = r.val;
            end
            if (w >= 0) begin
                r.id  = w;
                r.val = opnd(op_ax, w) * opnd(op_by, w) - opnd(op_ay, w) * opnd(op_bx, w);
                r.due = cyc + 1;
                pend.push_back(r);
                m_ptr = (w + 1) % NREQ;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b0;
        pend.delete();
        m_ptr = 0; m_cnt = 0; m_vld = 1'b0; m_id = 0; m_val = 0;
        #1;
        chk("rst_valid", longint'(res_valid), 0);
        chk("rst_id", longint'(res_id), 0);
        chk("rst_val", longint'(res_val), 0);
        chk("rst_pos", longint'(res_pos), 0);
        chk("rst_cnt", longint'(txn_cnt), 0);
        chk("rst_gnt", longint'(gnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] seq4 [5];
        logic [NREQ-1:0] alt  [4];

        #2;
        do_reset();

        // Directed single-transaction vectors: requester, ax, ay, bx, by, result, positive
        vt[0] = '{0, 3, 4, 5, 6, -2, 1'b0};
        vt[1] = '{1, 1023, -1024, 1023, 1023, 2094081, 1'b1};
        vt[2] = '{2, 0, 0, 0, 0, 0, 1'b0};
        vt[3] = '{3, -1024, -1024, 1023, -1024, 2096128, 1'b1};
        vt[4] = '{1, 1023, -1024, -1024, 1023, -2047, 1'b0};
        vt[5] = '{2, -1024, 1023, 1023, -1024, 2047, 1'b1};
        for (int v = 0; v < 6; v++) begin
            set_ops(vt[v].id, vt[v].ax, vt[v].ay, vt[v].bx, vt[v].by);
            req = NREQ'(1 << vt[v].id);
            step();
            req = '0;
            step();
            chk("vec_valid", longint'(res_valid), 1);
            chk("vec_id", longint'(res_id), vt[v].id);
            chk("vec_val", longint'(res_val), vt[v].val);
            chk("vec_pos", longint'(res_pos), longint'(vt[v].pos));
            step();
            chk("vec_drop", longint'(res_valid), 0);
        end

        // All four requesting from reset: strict rotation 0,1,2,3,0
        do_reset();
        seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, -i, 7, 2 * i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_all", longint'(last_gnt), longint'(seq4[k]));
        end
        chk("cnt5", longint'(txn_cnt), 5);

        // Pointer is now 1: requesters 0 and 2 alternate starting with 2
        alt = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_alt", longint'(last_gnt), longint'(alt[k]));
        end
        req = '0;
        repeat (3) step();

        // Reset right after an acceptance: nothing emerges and the pointer restarts at 0
        do_reset();
        req = 4'b0011;
        step();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_flush", longint'(res_valid), 0);
        end
        req = 4'b0101;
        step();
        chk("rst_ptr_gnt", longint'(last_gnt), 1);
        req = '0;
        repeat (3) step();

        // Counter saturation under continuous traffic
        do_reset();
        req = 4'b1111;
        repeat (65540) step();
        chk("cnt_sat", longint'(txn_cnt), 65535);
        req = '0;
        repeat (3) step();

        // Random traffic with holds, withdrawals and one mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && last_gnt[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    if (req[i]) set_ops(i, int'($signed(rnd_op())), int'($signed(rnd_op())),
                                        int'($signed(rnd_op())), int'($signed(rnd_op())));
                end else if (req[i]) begin
                    if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_ops(i, int'($signed(rnd_op())), int'($signed(rnd_op())),
                            int'($signed(rnd_op())), int'($signed(rnd_op())));
                    req[i] = 1'b1;
                end
            end
            step();
        end
        req = '0;
        repeat (4) step();

`ifdef CROSS_ARB_STALL_EN
        begin
            int          got[$];
            logic signed [RES_W-1:0] prev_val;
            bit          prev_stall;
            do_reset();
            model_on = 1'b0;
            for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 0, 0, 1);
            req = 4'b0011;
            prev_stall = 1'b0;
            prev_val   = '0;
            for (int c = 0; c < 20; c++) begin
                if (c == 4)  res_ready = 1'b0;
                if (c == 7)  res_ready = 1'b1;
                if (c == 12) req = '0;
                @(negedge clk);
                if (res_valid && !res_ready) begin
                    chk("stall_gnt", longint'(gnt), 0);
                    if (prev_stall) chk("stall_hold", longint'(res_val), longint'(prev_val));
                end
                if (res_valid && res_ready) got.push_back(int'(res_id));
                prev_stall = res_valid && !res_ready;
                prev_val   = res_val;
                @(posedge clk);
                #1;
            end
            chk("stall_count", got.size(), longint'(txn_cnt));
            for (int k = 0; k < got.size(); k++) chk("stall_order", got[k], k % 2);
            model_on = 1'b1;
            do_reset();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
